// File: rtl/ov7670_gen_pkg.sv
// Shared state codes, pattern codes, bar colours and colour helpers for the OV7670 source.
// LFSR_SEED/LFSR_TAPS are consumed only when OV_GEN_LFSR_EN is defined.
package ov7670_gen_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_VSYNC  = 3'd1;
  localparam state_t ST_VBACK  = 3'd2;
  localparam state_t ST_ACTIVE = 3'd3;
  localparam state_t ST_VFRONT = 3'd4;

  typedef logic [1:0] pattern_t;
  localparam pattern_t PAT_BARS  = 2'd0;
  localparam pattern_t PAT_RAMP  = 2'd1;
  localparam pattern_t PAT_SOLID = 2'd2;
  localparam pattern_t PAT_CHECK = 2'd3;

  localparam int CW = 16;

  // x^12+x^11+x^10+x^4+1 -> state bits 11,10,9,3
  localparam logic [11:0] LFSR_SEED = 12'hACE;
  localparam logic [11:0] LFSR_TAPS = 12'hE08;

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  // Replicating the top bits means the capture path's truncation returns the 444 colour exactly.
  function automatic logic [15:0] rgb444_to_565(input logic [11:0] c);
    return {c[11:8], c[11], c[7:4], c[7:6], c[3:0], c[3]};
  endfunction

endpackage

// File: rtl/ov7670_pattern_unit.sv
// Colour generator for the next pixel to be emitted; owns the bar counter and, with
// OV_GEN_LFSR_EN defined, the pattern-3 LFSR (otherwise pattern 3 is a checkerboard).
module ov7670_pattern_unit
  import ov7670_gen_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          px_valid,
  input  logic          px_odd,
  input  logic [CW-1:0] x,
  input  logic [3:0]    y_lsb,
  input  logic [3:0]    frame_lsb,
  input  logic [1:0]    pattern,
  input  logic [11:0]   solid_rgb,
  output logic [11:0]   rgb
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = $clog2(BAR_W + 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    bar_q, bar_d;
  logic [11:0]   alt_rgb;

  // Bar index advances on the first byte of each new pixel, no divider needed.
  always_comb begin
    bcnt_d = bcnt_q;
    bar_d  = bar_q;
    if (!px_valid || x == '0 || frame_start) begin
      bcnt_d = '0;
      bar_d  = '0;
    end else if (!px_odd) begin
      if (bcnt_q == BAR_LAST) begin
        bcnt_d = '0;
        bar_d  = bar_q + 3'd1;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt_q <= '0;
      bar_q  <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      bar_q  <= bar_d;
    end
  end

`ifdef OV_GEN_LFSR_EN
  logic [11:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      lfsr_q <= LFSR_SEED;
    end else if (px_valid && px_odd) begin
      lfsr_q <= {lfsr_q[10:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign alt_rgb = lfsr_q;
`else
  assign alt_rgb = (x[3] ^ y_lsb[3]) ? 12'hFFF : 12'h000;
`endif

  always_comb begin
    case (pattern)
      PAT_BARS:  rgb = bar_colour(bar_d);
      PAT_RAMP:  rgb = {x[3:0], y_lsb, frame_lsb};
      PAT_SOLID: rgb = solid_rgb;
      default:   rgb = alt_rgb;
    endcase
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670-style RGB565 byte stream source (vsync/href/d) with frame sequencing.
// Define OV_GEN_LFSR_EN to turn pattern 3 into an LFSR noise pattern.
module ov7670_stream_gen
  import ov7670_gen_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 288,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  localparam int L     = 2 * H_ACTIVE + H_BLANK;
  localparam int BCW   = $clog2(L);
  localparam int MAX_A = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int MAX_B = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int MAXL  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int LNW   = $clog2(MAXL + 1);

  localparam logic [BCW-1:0] BC_LAST = BCW'(L - 1);
  localparam logic [BCW-1:0] BC_HREF = BCW'(2 * H_ACTIVE);
  localparam logic [LNW-1:0] LN_VS   = LNW'(VSYNC_LINES - 1);
  localparam logic [LNW-1:0] LN_VB   = LNW'(V_BACK - 1);
  localparam logic [LNW-1:0] LN_ACT  = LNW'(V_ACTIVE - 1);
  localparam logic [LNW-1:0] LN_VF   = LNW'(V_FRONT - 1);

  state_t         state_q, state_d;
  logic [BCW-1:0] bc_q, bc_d;
  logic [LNW-1:0] ln_q, ln_d, ln_last;
  logic [1:0]     pat_q, pat_d;
  logic           vsync_q, vsync_d, href_q, href_d, frame_done_q, frame_done_d;
  logic [7:0]     d_q, d_d, frame_count_q, frame_count_d;
  logic           frame_start;
  logic [CW-1:0]  x_d;
  logic [11:0]    rgb;
  logic [15:0]    pix565;

  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    ln_d    = ln_q;
    case (state_q)
      ST_VSYNC:  ln_last = LN_VS;
      ST_VBACK:  ln_last = LN_VB;
      ST_ACTIVE: ln_last = LN_ACT;
      default:   ln_last = LN_VF;
    endcase
    if (state_q == ST_IDLE) begin
      bc_d = '0;
      ln_d = '0;
      if (enable) state_d = ST_VSYNC;
    end else if (bc_q == BC_LAST) begin
      bc_d = '0;
      if (ln_q == ln_last) begin
        ln_d = '0;
        case (state_q)
          ST_VSYNC:  state_d = ST_VBACK;
          ST_VBACK:  state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFRONT;
          default:   state_d = enable ? ST_VSYNC : ST_IDLE;
        endcase
      end else begin
        ln_d = ln_q + LNW'(1);
      end
    end else begin
      bc_d = bc_q + BCW'(1);
    end
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  assign frame_start   = (state_d == ST_VSYNC) && (state_q != ST_VSYNC);
  assign pat_d         = frame_start ? pattern_sel : pat_q;
  assign vsync_d       = (state_d == ST_VSYNC);
  assign href_d        = (state_d == ST_ACTIVE) && (bc_d < BC_HREF);
  assign frame_done_d  = (state_d == ST_VFRONT) && (bc_d == BC_LAST) && (ln_d == LN_VF);
  assign frame_count_d = frame_count_q + 8'(frame_done_d);
  assign x_d           = CW'(bc_d >> 1);
  assign pix565        = rgb444_to_565(rgb);
  assign d_d           = !href_d ? 8'h00 : (bc_d[0] ? pix565[7:0] : pix565[15:8]);

  ov7670_pattern_unit #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .clk         (pclk),
    .reset       (reset),
    .frame_start (frame_start),
    .px_valid    (href_d),
    .px_odd      (bc_d[0]),
    .x           (x_d),
    .y_lsb       (4'(ln_d)),
    .frame_lsb   (frame_count_q[3:0]),
    .pattern     (pat_q),
    .solid_rgb   (solid_rgb),
    .rgb         (rgb)
  );

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bc_q          <= '0;
      ln_q          <= '0;
      pat_q         <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      d_q           <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      bc_q          <= bc_d;
      ln_q          <= ln_d;
      pat_q         <= pat_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      d_q           <= d_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign vsync       = vsync_q;
  assign href        = href_q;
  assign d           = d_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule
